// File: rtl/enigma_pkg.sv
// Shared PS/2 constants and prefix-FSM state type for the Enigma board keyboard/display path.
package enigma_pkg;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] BLANK_CODE = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    BREAK,
    EXT,
    EXT_BREAK
  } prefix_state_t;

  // Keyboard status bytes and the blank code never represent a key.
  function automatic logic is_key_code(input logic [7:0] c);
    return !(c == BLANK_CODE || c == PS2_BAT || c == PS2_ACK || c == PS2_RESEND);
  endfunction

endpackage

// File: rtl/digit_refresh_counter.sv
// Refresh prescaler: holds each digit for REFRESH_DIV cycles, then advances the digit index.
module digit_refresh_counter #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic             clock,
  input  logic             reset,
  output logic [IDX_W-1:0] index
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      index <= '0;
    end else if (count == CNT_W'(REFRESH_DIV - 1)) begin
      count <= '0;
      index <= (index == IDX_W'(NUM_DIGITS - 1)) ? '0 : index + 1'b1;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/scan_display_scheduler.sv
// Filters PS/2 make codes into a NUM_DIGITS shift buffer and time-multiplexes
// one shared scan-code decoder across active-low common-anode digits.
module scan_display_scheduler
  import enigma_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  code_valid,
  input  logic [7:0]            code,
  input  logic                  clear,
  output logic [7:0]            digit_code,
  output logic [NUM_DIGITS-1:0] anode_n,
  output logic                  key_strobe,
  output logic [7:0]            last_key
);

  prefix_state_t    state, state_next;
  logic             held;
  logic             accept;
  logic             release_held;
  logic [7:0]       buffer [NUM_DIGITS];
  logic [IDX_W-1:0] digit_index;

  // Prefix FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Prefix FSM: next state, advancing only on a received byte
  always_comb begin
    // NOTE: a default before any branch keeps this combinational block from
    // inferring a latch on paths that do not assign it.
    state_next = state;
    if (code_valid) begin
      unique case (state)
        IDLE: begin
          if (code == PS2_BREAK)    state_next = BREAK;
          else if (code == PS2_EXT) state_next = EXT;
        end
        EXT:       state_next = (code == PS2_BREAK) ? EXT_BREAK : IDLE;
        BREAK:     state_next = IDLE;
        EXT_BREAK: state_next = IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  // Prefix FSM: outputs. A held key re-sending the same make code is typematic repeat.
  always_comb begin
    accept       = 1'b0;
    release_held = 1'b0;
    if (code_valid) begin
      if (state == IDLE && code != PS2_BREAK && code != PS2_EXT &&
          is_key_code(code) && !(held && code == last_key))
        accept = 1'b1;
      if (state == BREAK)
        release_held = 1'b1;
    end
  end

  // Key tracking and shift buffer; clear overrides the shift but not the key tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      held       <= 1'b0;
      last_key   <= BLANK_CODE;
      key_strobe <= 1'b0;
      // NOTE: the buffer is reset on purpose so the display comes up blank;
      // storage that does not need a defined start value would be left unreset.
      for (int i = 0; i < NUM_DIGITS; i++) buffer[i] <= BLANK_CODE;
    end else begin
      key_strobe <= accept;
      if (accept) begin
        last_key <= code;
        held     <= 1'b1;
      end else if (release_held) begin
        held <= 1'b0;
      end
      if (clear) begin
        for (int i = 0; i < NUM_DIGITS; i++) buffer[i] <= BLANK_CODE;
      end else if (accept) begin
        for (int i = 1; i < NUM_DIGITS; i++) buffer[i] <= buffer[i-1];
        buffer[0] <= code;
      end
    end
  end

  digit_refresh_counter #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_refresh (
    .clock (clock),
    .reset (reset),
    .index (digit_index)
  );

  // Code and anode are registered together so the decoder never sees a mismatched pair.
  always_ff @(posedge clock) begin
    if (reset) begin
      digit_code <= BLANK_CODE;
      anode_n    <= ~NUM_DIGITS'(1);
    end else begin
      digit_code <= buffer[digit_index];
      anode_n    <= ~(NUM_DIGITS'(1) << digit_index);
    end
  end

endmodule

// File: tb/tb_scan_display_scheduler.sv
// Directed bench for scan_display_scheduler with a fast refresh (REFRESH_DIV=3, 4 digits).
module tb_scan_display_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       code_valid;
  logic [7:0] code;
  logic       clear;
  logic [7:0] digit_code;
  logic [3:0] anode_n;
  logic       key_strobe;
  logic [7:0] last_key;

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  int strobe_base;

  scan_display_scheduler #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .code_valid (code_valid),
    .code       (code),
    .clear      (clear),
    .digit_code (digit_code),
    .anode_n    (anode_n),
    .key_strobe (key_strobe),
    .last_key   (last_key)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (key_strobe) strobe_cnt++;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // One byte strobe; key_strobe must be high for exactly the following cycle iff accepted.
  task automatic send(input logic [7:0] c, input logic exp_accept);
    @(negedge clock);
    code_valid = 1'b1;
    code       = c;
    @(posedge clock);
    @(negedge clock);
    code_valid = 1'b0;
    code       = 8'h00;
    check($sformatf("strobe_%h", c), 32'(key_strobe), 32'(exp_accept));
    @(negedge clock);
    check($sformatf("strobe_end_%h", c), 32'(key_strobe), 32'd0);
  endtask

  // Watch a full refresh rotation and compare each digit's code against expectation.
  task automatic verify_digits(input string tag, input logic [3:0][7:0] exp);
    logic [3:0][7:0] got;
    logic [3:0]      seen;
    got  = '0;
    seen = '0;
    for (int c = 0; c < 40 && seen != 4'hF; c++) begin
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
        if (anode_n == ~(4'b0001 << i)) begin
          got[i]  = digit_code;
          seen[i] = 1'b1;
        end
      end
    end
    check({tag, "_scan_done"}, 32'(seen), 32'hF);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_digit%0d", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_anode;
    int         waited;

    reset      = 1'b1;
    code_valid = 1'b0;
    code       = 8'h00;
    clear      = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_anode_n", 32'(anode_n), 32'hE);
    check("rst_digit_code", 32'(digit_code), 32'h00);
    check("rst_key_strobe", 32'(key_strobe), 32'd0);
    check("rst_last_key", 32'(last_key), 32'h00);
    reset = 1'b0;

    // Four letters with gaps
    strobe_base = strobe_cnt;
    send(8'h1C, 1'b1);
    send(8'h32, 1'b1);
    send(8'h21, 1'b1);
    send(8'h23, 1'b1);
    check("four_strobes", 32'(strobe_cnt - strobe_base), 32'd4);
    check("last_key_23", 32'(last_key), 32'h23);
    verify_digits("fill", {8'h1C, 8'h32, 8'h21, 8'h23});

    // Auto-repeat suppression and break release
    strobe_base = strobe_cnt;
    send(8'h1C, 1'b1);
    send(8'h1C, 1'b0);
    send(8'h1C, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    send(8'h1C, 1'b1);
    check("repeat_strobes", 32'(strobe_cnt - strobe_base), 32'd2);
    verify_digits("repeat", {8'h21, 8'h23, 8'h1C, 8'h1C});

    // Extended make/break and status bytes are all dropped
    strobe_base = strobe_cnt;
    send(8'hE0, 1'b0);
    send(8'h75, 1'b0);
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h75, 1'b0);
    send(8'hAA, 1'b0);
    send(8'hFA, 1'b0);
    send(8'hFE, 1'b0);
    send(8'h00, 1'b0);
    check("ext_strobes", 32'(strobe_cnt - strobe_base), 32'd0);
    verify_digits("ext", {8'h21, 8'h23, 8'h1C, 8'h1C});
    send(8'h1B, 1'b1);
    verify_digits("idle_again", {8'h23, 8'h1C, 8'h1C, 8'h1B});

    // Refresh rotation: sync to the first 1101 cycle, then 3 cycles per digit
    waited = 0;
    @(negedge clock);
    while (anode_n != 4'b1101 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    check("refresh_sync", 32'(anode_n), 32'hD);
    for (int k = 0; k < 12; k++) begin
      exp_anode = ~(4'b0001 << ((1 + k / 3) % 4));
      check($sformatf("refresh_c%0d", k), 32'(anode_n), 32'(exp_anode));
      @(negedge clock);
    end
    check("refresh_wrap", 32'(anode_n), 32'hD);

    // Clear coincident with an accepted make code
    @(negedge clock);
    code_valid = 1'b1;
    code       = 8'h2B;
    clear      = 1'b1;
    @(posedge clock);
    @(negedge clock);
    code_valid = 1'b0;
    code       = 8'h00;
    clear      = 1'b0;
    check("clr_key_strobe", 32'(key_strobe), 32'd1);
    check("clr_last_key", 32'(last_key), 32'h2B);
    verify_digits("clr", {8'h00, 8'h00, 8'h00, 8'h00});

    // Reset between a break prefix and its key byte
    send(8'hF0, 1'b0);
    pulse_reset();
    check("midrst_last_key", 32'(last_key), 32'h00);
    send(8'h24, 1'b1);
    check("midrst_accept_key", 32'(last_key), 32'h24);
    verify_digits("midrst", {8'h00, 8'h00, 8'h00, 8'h24});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
